// File: rtl/shot_dispatcher.sv
// Projectile slot manager: spawns shots on biker requests, moves them up each frame,
// retires them on exit/collision/clearAll, and draws them. Optional macro: SHOT_QUEUE_EN.
module shot_dispatcher #(
  parameter int         NUM_SHOTS       = 4,
  parameter int         SHOT_SPEED_Y    = 8,
  parameter int         SHOT_W          = 4,
  parameter int         SHOT_H          = 8,
  parameter int         BIKER_W         = 32,
  parameter int         COOLDOWN_TENTHS = 3,
  parameter logic [7:0] SHOT_COLOR      = 8'hE0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        shootRequest,
  input  logic [10:0] bikerTLX,
  input  logic [10:0] bikerTLY,
  input  logic        startOfFrame,
  input  logic        oneTensSec,
  input  logic        clearAll,
  input  logic        shotCollision,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic        shootAck,
  output logic        shootDrop,
  output logic [3:0]  activeCount,
  output logic        drawingRequest,
  output logic [7:0]  RGBout
);

  localparam int          IDX_W    = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1;
  localparam logic [10:0] SPAWN_DX = 11'(BIKER_W / 2 - SHOT_W / 2);
  localparam logic [10:0] SPEED    = 11'(SHOT_SPEED_Y);
  localparam logic [10:0] H11      = 11'(SHOT_H);
  localparam logic [11:0] W12      = 12'(SHOT_W);
  localparam logic [11:0] H12      = 12'(SHOT_H);
  localparam logic [7:0]  CD_LOAD  = 8'(COOLDOWN_TENTHS);

  logic [NUM_SHOTS-1:0] active_q, active_d;
  logic [10:0]          x_q [NUM_SHOTS];
  logic [10:0]          x_d [NUM_SHOTS];
  logic [10:0]          y_q [NUM_SHOTS];
  logic [10:0]          y_d [NUM_SHOTS];
  logic [7:0]           cooldown_q, cooldown_d;
  logic                 ack_q, ack_d;
  logic                 drop_q, drop_d;
  logic                 draw_q, draw_d;
  logic [7:0]           rgb_q, rgb_d;
  logic [IDX_W-1:0]     drawn_slot_q, drawn_slot_d;
  logic [3:0]           count_q, count_d;

  logic [NUM_SHOTS-1:0] hit;
  logic                 free_any;
  logic [IDX_W-1:0]     free_idx;
  logic                 can_alloc;
  logic                 alloc_en;
  logic [10:0]          src_x, src_y;
  logic [10:0]          spawn_x, spawn_y;

  // Lowest-index free slot; a slot retiring this cycle still reads as busy.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign can_alloc = (cooldown_q == 8'd0) && free_any && !clearAll;

`ifdef SHOT_QUEUE_EN
  logic        pend_q, pend_d;
  logic [10:0] pend_x_q, pend_x_d;
  logic [10:0] pend_y_q, pend_y_d;

  // A pending request is older than a new one, so it is served first; the new one
  // then takes over the freed buffer.
  always_comb begin
    alloc_en = 1'b0;
    src_x    = bikerTLX;
    src_y    = bikerTLY;
    ack_d    = 1'b0;
    drop_d   = 1'b0;
    pend_d   = pend_q;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    if (clearAll) begin
      pend_d = 1'b0;
      drop_d = shootRequest;
    end else if (pend_q && can_alloc) begin
      alloc_en = 1'b1;
      src_x    = pend_x_q;
      src_y    = pend_y_q;
      ack_d    = 1'b1;
      pend_d   = shootRequest;
      pend_x_d = bikerTLX;
      pend_y_d = bikerTLY;
    end else if (shootRequest) begin
      if (!pend_q && can_alloc) begin
        alloc_en = 1'b1;
        ack_d    = 1'b1;
      end else begin
        drop_d   = pend_q;
        pend_d   = 1'b1;
        pend_x_d = bikerTLX;
        pend_y_d = bikerTLY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q   <= 1'b0;
      pend_x_q <= '0;
      pend_y_q <= '0;
    end else begin
      pend_q   <= pend_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
    end
  end
`else
  always_comb begin
    alloc_en = shootRequest && can_alloc;
    src_x    = bikerTLX;
    src_y    = bikerTLY;
    ack_d    = alloc_en;
    drop_d   = shootRequest && !can_alloc;
  end
`endif

  assign spawn_x = src_x + SPAWN_DX;
  assign spawn_y = (src_y < H11) ? 11'd0 : src_y - H11;

  // Priority within a cycle: move < retire (collision) < allocate < clearAll.
  always_comb begin
    active_d = active_q;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
    end
    cooldown_d = cooldown_q;
    if (oneTensSec && cooldown_q != 8'd0) cooldown_d = cooldown_q - 8'd1;

    if (startOfFrame) begin
      for (int i = 0; i < NUM_SHOTS; i++) begin
        if (active_q[i]) begin
          if (y_q[i] < SPEED) active_d[i] = 1'b0;
          else                y_d[i]      = y_q[i] - SPEED;
        end
      end
    end

    if (draw_q && shotCollision) begin
      active_d[drawn_slot_q] = 1'b0;
      y_d[drawn_slot_q]      = y_q[drawn_slot_q];
    end

    if (alloc_en) begin
      active_d[free_idx] = 1'b1;
      x_d[free_idx]      = spawn_x;
      y_d[free_idx]      = spawn_y;
      cooldown_d         = CD_LOAD;
    end

    if (clearAll) begin
      active_d   = '0;
      cooldown_d = 8'd0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SHOTS; gi++) begin : g_slot
      logic [11:0] x_lo, y_lo;
      assign x_lo = {1'b0, x_q[gi]};
      assign y_lo = {1'b0, y_q[gi]};
      // 12-bit compare so a shot near the right edge does not wrap its extent.
      assign hit[gi] = active_q[gi]
                     && ({1'b0, pixelX} >= x_lo) && ({1'b0, pixelX} < x_lo + W12)
                     && ({1'b0, pixelY} >= y_lo) && ({1'b0, pixelY} < y_lo + H12);

      always_ff @(posedge clk) begin
        if (reset) begin
          active_q[gi] <= 1'b0;
          x_q[gi]      <= '0;
          y_q[gi]      <= '0;
        end else begin
          active_q[gi] <= active_d[gi];
          x_q[gi]      <= x_d[gi];
          y_q[gi]      <= y_d[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    draw_d       = |hit;
    drawn_slot_d = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (hit[i]) drawn_slot_d = IDX_W'(i);
    end
    rgb_d   = draw_d ? SHOT_COLOR : 8'h00;
    count_d = '0;
    for (int i = 0; i < NUM_SHOTS; i++) count_d = count_d + 4'(active_q[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cooldown_q   <= '0;
      ack_q        <= 1'b0;
      drop_q       <= 1'b0;
      draw_q       <= 1'b0;
      rgb_q        <= 8'h00;
      drawn_slot_q <= '0;
      count_q      <= '0;
    end else begin
      cooldown_q   <= cooldown_d;
      ack_q        <= ack_d;
      drop_q       <= drop_d;
      draw_q       <= draw_d;
      rgb_q        <= rgb_d;
      drawn_slot_q <= drawn_slot_d;
      count_q      <= count_d;
    end
  end

  assign shootAck       = ack_q;
  assign shootDrop      = drop_q;
  assign activeCount    = count_q;
  assign drawingRequest = draw_q;
  assign RGBout         = rgb_q;

endmodule

// File: tb/tb_shot_dispatcher.sv
// Scoreboard bench for shot_dispatcher (default build): stimulus pushes expectations,
// a negedge monitor pops and compares whenever the DUT presents a response.
module tb_shot_dispatcher;

  logic        clk = 1'b0;
  logic        reset, shootRequest, startOfFrame, oneTensSec, clearAll, shotCollision;
  logic [10:0] bikerTLX, bikerTLY, pixelX, pixelY;
  logic        shootAck, shootDrop, drawingRequest;
  logic [3:0]  activeCount;
  logic [7:0]  RGBout;

  always #5 clk = ~clk;

  shot_dispatcher dut (
    .clk(clk), .reset(reset), .shootRequest(shootRequest),
    .bikerTLX(bikerTLX), .bikerTLY(bikerTLY), .startOfFrame(startOfFrame),
    .oneTensSec(oneTensSec), .clearAll(clearAll), .shotCollision(shotCollision),
    .pixelX(pixelX), .pixelY(pixelY), .shootAck(shootAck), .shootDrop(shootDrop),
    .activeCount(activeCount), .drawingRequest(drawingRequest), .RGBout(RGBout)
  );

  typedef struct { bit ack; string name; } ev_t;
  typedef struct { bit draw; logic [7:0] rgb; string name; } pix_t;
  typedef struct { int cnt; string name; } cnt_t;

  ev_t  ev_q[$];
  pix_t pix_q[$];
  cnt_t cnt_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   probe_strobe = 1'b0, probe_d1 = 1'b0;
  bit   cnt_strobe = 1'b0, cnt_d1 = 1'b0;

  always @(posedge clk) begin
    probe_d1 <= probe_strobe;
    cnt_d1   <= cnt_strobe;
  end

  // Monitor
  always @(negedge clk) begin
    if (shootAck || shootDrop) begin
      ev_t e;
      n_tests++;
      if (ev_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: ack=%0b drop=%0b, required no response", shootAck, shootDrop);
      end else begin
        e = ev_q.pop_front();
        if (shootAck !== e.ack || shootDrop !== !e.ack) begin
          n_fail++;
          $display("FAIL %s: ack=%0b drop=%0b, required ack=%0b drop=%0b",
                   e.name, shootAck, shootDrop, e.ack, !e.ack);
        end else
          $display("[TB] %s: %s", e.name, e.ack ? "ack" : "drop");
      end
    end
    if (probe_d1) begin
      pix_t p;
      n_tests++;
      if (pix_q.size() == 0) begin
        n_fail++;
        $display("FAIL probe_underflow: no expectation queued");
      end else begin
        p = pix_q.pop_front();
        if (drawingRequest !== p.draw || RGBout !== p.rgb) begin
          n_fail++;
          $display("FAIL %s: draw=%0b rgb=%h, required draw=%0b rgb=%h",
                   p.name, drawingRequest, RGBout, p.draw, p.rgb);
        end else
          $display("[TB] %s: draw=%0b rgb=%h", p.name, drawingRequest, RGBout);
      end
    end
    if (cnt_d1) begin
      cnt_t c;
      n_tests++;
      if (cnt_q.size() == 0) begin
        n_fail++;
        $display("FAIL count_underflow: no expectation queued");
      end else begin
        c = cnt_q.pop_front();
        if (activeCount !== 4'(c.cnt)) begin
          n_fail++;
          $display("FAIL %s: activeCount=%0d, required %0d", c.name, activeCount, c.cnt);
        end else
          $display("[TB] %s: activeCount=%0d", c.name, activeCount);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp_v);
    end else
      $display("[TB] %s: %0d", nm, act);
  endtask

  task automatic shoot(input int x, input int y, input bit exp_ack, input string nm,
                       input bit tick = 1'b0, input bit clr = 1'b0);
    shootRequest = 1'b1;
    bikerTLX     = 11'(x);
    bikerTLY     = 11'(y);
    oneTensSec   = tick;
    clearAll     = clr;
    ev_q.push_back('{exp_ack, nm});
    @(negedge clk);
    shootRequest = 1'b0;
    oneTensSec   = 1'b0;
    clearAll     = 1'b0;
  endtask

  task automatic probe(input int x, input int y, input bit exp_draw, input string nm);
    pixelX       = 11'(x);
    pixelY       = 11'(y);
    probe_strobe = 1'b1;
    pix_q.push_back('{exp_draw, exp_draw ? 8'hE0 : 8'h00, nm});
    @(negedge clk);
    probe_strobe = 1'b0;
    pixelX       = 11'd2000;
    pixelY       = 11'd2000;
  endtask

  task automatic count(input int exp_c, input string nm);
    cnt_strobe = 1'b1;
    cnt_q.push_back('{exp_c, nm});
    @(negedge clk);
    cnt_strobe = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
    end
  endtask

  task automatic tenths(input int n);
    repeat (n) begin
      oneTensSec = 1'b1;
      @(negedge clk);
      oneTensSec = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; shootRequest = 1'b0; startOfFrame = 1'b0; oneTensSec = 1'b0;
    clearAll = 1'b0; shotCollision = 1'b0; bikerTLX = '0; bikerTLY = '0;
    pixelX = 11'd2000; pixelY = 11'd2000;
    repeat (3) @(negedge clk);
    chk("rst_ack", int'(shootAck), 0);
    chk("rst_drop", int'(shootDrop), 0);
    chk("rst_draw", int'(drawingRequest), 0);
    chk("rst_rgb", int'(RGBout), 0);
    chk("rst_count", int'(activeCount), 0);
    reset = 1'b0;
    @(negedge clk);

    // First shot: slot0 at X=114, Y=392
    shoot(100, 400, 1'b1, "spawn0");
    count(1, "count_after_spawn0");
    probe(114, 392, 1'b1, "s0_topleft");
    probe(117, 399, 1'b1, "s0_botright");
    probe(118, 392, 1'b0, "s0_right_edge");
    probe(114, 391, 1'b0, "s0_above");
    probe(113, 395, 1'b0, "s0_left");

    // Two frames: Y=376
    frames(2);
    probe(115, 380, 1'b1, "s0_after_2f");
    probe(115, 376, 1'b1, "s0_top_2f");
    probe(115, 384, 1'b0, "s0_below_2f");

    // Cooldown still loaded (3), then fill slots spaced by 3 ticks
    shoot(200, 300, 1'b0, "cooldown_block");
    tenths(3);
    shoot(200, 300, 1'b1, "spawn1");
    tenths(3);
    shoot(300, 200, 1'b1, "spawn2");
    tenths(3);
    shoot(400, 100, 1'b1, "spawn3");
    tenths(3);
    shoot(500, 50, 1'b0, "full_drop");
    count(4, "count_full");

    // Collide with slot1 (214,292) in the same cycle as a frame
    probe(215, 293, 1'b1, "s1_drawn");
    shotCollision = 1'b1;
    startOfFrame  = 1'b1;
    @(negedge clk);
    shotCollision = 1'b0;
    startOfFrame  = 1'b0;
    probe(215, 292, 1'b0, "s1_gone_unmoved");
    probe(215, 284, 1'b0, "s1_gone_moved");
    probe(114, 368, 1'b1, "s0_moved");
    probe(114, 376, 1'b0, "s0_old_pos");
    probe(314, 184, 1'b1, "s2_moved");
    probe(314, 192, 1'b0, "s2_old_pos");
    count(3, "count_after_coll");

    // Collision with nothing drawn is ignored
    shotCollision = 1'b1;
    @(negedge clk);
    shotCollision = 1'b0;
    count(3, "count_coll_ignored");

    // Slot3 from Y=84 to Y=4, then retires
    frames(10);
    probe(414, 4, 1'b1, "s3_at_y4");
    probe(414, 3, 1'b0, "s3_above_y4");
    frames(1);
    count(2, "count_s3_retired");

    // Spawn Y clamp: bikerTLY=3 -> Y=0 in slot1, X=14
    shoot(0, 3, 1'b1, "spawn_clamp");
    probe(14, 0, 1'b1, "clamp_top");
    probe(17, 7, 1'b1, "clamp_bot");
    probe(14, 8, 1'b0, "clamp_below");
    probe(18, 0, 1'b0, "clamp_right");
    frames(1);
    count(2, "count_clamp_retired");

    // Spawn X wraps: 2040+14 = 6
    tenths(3);
    shoot(2040, 500, 1'b1, "spawn_wrap");
    probe(6, 492, 1'b1, "wrap_hit");
    probe(9, 499, 1'b1, "wrap_corner");
    probe(5, 492, 1'b0, "wrap_left");
    count(3, "count_wrap");

    // clearAll with a request in the same cycle
    shoot(100, 100, 1'b0, "clear_req", 1'b0, 1'b1);
    count(0, "count_cleared");
    probe(114, 272, 1'b0, "s0_cleared");
    shoot(100, 400, 1'b1, "cd_cleared_ack");

    // Reset mid-flight
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    probe(114, 392, 1'b0, "reset_discard");
    count(0, "count_reset");

    // Load beats a simultaneous tick
    shoot(100, 400, 1'b1, "cd_tick_load", 1'b1);
    tenths(2);
    shoot(100, 400, 1'b0, "cd_one_left");
    tenths(1);
    shoot(100, 400, 1'b1, "cd_expired");
    count(2, "count_final");

    repeat (3) @(negedge clk);
    chk("events_drained", ev_q.size(), 0);
    chk("probes_drained", pix_q.size(), 0);
    chk("counts_drained", cnt_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shot_dispatcher.md
Name: shot_dispatcher

Overview:
- Responder for the biker shoot-request interface: accepts single-cycle shoot pulses with biker top-left coordinates, allocates a projectile slot, moves live projectiles upward once per frame, and retires them on screen exit or collision.
- Sits beside the biker top level; its drawing request and RGB output feed the frame mux, and its collision input comes from the collision matrix.

Parameters:
- NUM_SHOTS, 4, number of concurrent projectile slots (1..8).
- SHOT_SPEED_Y, 8, pixels moved upward per startOfFrame.
- SHOT_W, 4, projectile width in pixels.
- SHOT_H, 8, projectile height in pixels.
- BIKER_W, 32, shooter width, used to centre the spawn.
- COOLDOWN_TENTHS, 3, oneTensSec ticks blocked after each accepted shot.
- SHOT_COLOR, 8'hE0, RGB332 projectile colour.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- shootRequest  in  1  one-cycle request pulse from the biker.
- bikerTLX  in  11  shooter top-left X, sampled with the request.
- bikerTLY  in  11  shooter top-left Y, sampled with the request.
- startOfFrame  in  1  one-cycle pulse per frame.
- oneTensSec  in  1  one-cycle pulse every 0.1 s.
- clearAll  in  1  level end; kills all shots.
- shotCollision  in  1  collision involving the currently drawn shot pixel.
- pixelX  in  11  current scan X.
- pixelY  in  11  current scan Y.
- shootAck  out  1  one-cycle pulse: request accepted.
- shootDrop  out  1  one-cycle pulse: request rejected.
- activeCount  out  4  number of live slots.
- drawingRequest  out  1  current pixel lies inside a live shot.
- RGBout  out  8  SHOT_COLOR when drawingRequest is high, else 8'h00.

Behaviour:
- Reset (sync, high): all slots inactive; cooldown 0; shootAck, shootDrop, drawingRequest 0; RGBout 0; activeCount 0. A reset mid-flight discards all shots.
- Slot state: active bit, X[10:0], Y[10:0].
- Accept rule, evaluated in the cycle shootRequest is high: the request is accepted if cooldown == 0 and a free slot exists.
  - The lowest-index free slot is allocated.
  - Spawn X = bikerTLX + BIKER_W/2 - SHOT_W/2.
  - Spawn Y = bikerTLY - SHOT_H, or 0 if bikerTLY < SHOT_H.
  - cooldown is loaded with COOLDOWN_TENTHS.
  - shootAck pulses on the next cycle (latency 1).
- Otherwise the request is rejected and shootDrop pulses on the next cycle. shootAck and shootDrop are never high together.
- Cooldown: decrements on oneTensSec, saturating at 0. A load in the same cycle as a tick takes priority over the decrement.
- Movement on startOfFrame, for each active slot:
  - If Y < SHOT_SPEED_Y, the slot retires (inactive).
  - Otherwise Y = Y - SHOT_SPEED_Y.
  - A slot spawned in the same cycle is not moved that frame.
- Drawing:
  - A slot hits when pixelX is in [X, X+SHOT_W) and pixelY is in [Y, Y+SHOT_H).
  - drawingRequest and RGBout are registered, one cycle after the pixel.
  - The lowest-index hitting slot is the drawn slot, recorded in drawnSlot.
- Collision: shotCollision is sampled while drawingRequest is high. The slot in drawnSlot retires on the next cycle. shotCollision while drawingRequest is low is ignored.
- Simultaneous events on one slot: retire (collision or clearAll) beats movement, and movement beats nothing. A collision-retire and an allocation to the same freed slot in the same cycle: the retire completes first, and the slot becomes allocatable from the following cycle.
- clearAll: all slots inactive next cycle; cooldown cleared; a request in the same cycle is dropped.
- activeCount: registered popcount of the active bits, updated one cycle after any change.
- Arithmetic: 11-bit unsigned. Spawn X wraps modulo 2048. The Y subtraction is guarded by the retire compare, so it never underflows.

Optional Feature:
- Macro: SHOT_QUEUE_EN.
- Defined: a one-deep pending buffer holds a rejected request (with its coordinates) instead of pulsing shootDrop.
  - The pending request is served on the first cycle with cooldown == 0 and a free slot; shootAck then pulses on the next cycle.
  - A new request arriving while pending is full overwrites it and pulses shootDrop for the old request.
  - clearAll and reset empty the buffer.
- Undefined: no buffer; every rejected request pulses shootDrop immediately.

Test Plan:
- Reset, then shootRequest with bikerTLX=100, bikerTLY=400 -> shootAck after 1 cycle; slot0 X=114, Y=392; activeCount=1.
- Two frames after the spawn -> slot0 Y=376; pixel (115,380) -> drawingRequest=1 and RGBout=8'hE0 one cycle later.
- Five requests, each spaced by 3 oneTensSec ticks -> 4 acks, then shootDrop on the 5th; a request before the cooldown expires -> shootDrop.
- Shot at Y=5 on startOfFrame -> retires; activeCount decrements.
- shotCollision while drawing slot1 and startOfFrame in the same cycle -> slot1 retires, not moved; other slots move by 8.
- SHOT_QUEUE_EN with all slots full and a request pending -> a collision frees a slot; pending is allocated and shootAck pulses; clearAll with a pending request -> buffer empty, no ack.
